// File: rtl/cfm_poll_pkg.sv
// Shared types and constants for the CFM poll master and its UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cfm_poll_pkg;

    // Poll sequencer states
    typedef enum logic [2:0] {
        IDLE,
        TX_BIT,
        GAP,
        RX_WAIT,
        RX_BIT,
        FINISH
    } state_t;

    // Why the poll ended; selects which pulse fires in FINISH
    typedef enum logic [1:0] {
        FIN_DONE,
        FIN_TIMEOUT,
        FIN_FRAME
    } fin_t;

    // UART frame layout
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Default link timing
    localparam int DEF_BAUD_DIV = 16;
    localparam int DEF_RESP_LEN = 32;
    localparam int DEF_TIMEOUT  = 4096;
    localparam int DEF_TURN_GAP = 32;

endpackage

// File: rtl/cfm_rx_byte.sv
// UART byte receiver: 2-flop rx synchroniser, start-edge detect, mid-bit sampling, stop check.
// Latency: result pulses in the cycle the stop bit is sampled (BAUD_DIV/2 + 9*BAUD_DIV after the edge).
// Backpressure: none; parent must consume byte_valid/frame_err/false_start in the pulse cycle.
//
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   rx            asynchronous serial input
//   enable        from parent FSM; low forces the receiver idle
//   start_seen    pulse: falling edge accepted, byte reception begins
//   false_start   pulse: start bit sampled high at mid-bit, reception abandoned
//   byte_valid    pulse: stop bit high, byte_data holds the received byte
//   frame_err     pulse: stop bit sampled low
//   byte_data     assembled byte, LSB received first
module cfm_rx_byte
    import cfm_poll_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       enable,
    output logic       start_seen,
    output logic       false_start,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] byte_data
);

    localparam int              BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    // Loading this on the edge makes the first sample land BAUD_DIV/2 cycles later.
    localparam logic [BW-1:0]   HALF_LOAD = BW'(BAUD_DIV - BAUD_DIV / 2);
    localparam logic [3:0]      STOP_IDX  = 4'(DATA_BITS + 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          active;
    logic [BW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sample;

    // Synchroniser resets to line-idle so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign sample      = active && (cnt == BAUD_LAST);
    assign start_seen  = enable && !active && rx_prev && !rx_sync;
    assign false_start = sample && (bit_idx == 4'd0) && (rx_sync != START_BIT);
    assign byte_valid  = sample && (bit_idx == STOP_IDX) && (rx_sync == STOP_BIT);
    assign frame_err   = sample && (bit_idx == STOP_IDX) && (rx_sync != STOP_BIT);
    assign byte_data   = shreg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (!enable) begin
            active <= 1'b0;
        end else if (start_seen) begin
            active  <= 1'b1;
            cnt     <= HALF_LOAD;
            bit_idx <= '0;
        end else if (sample) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd0) begin
                if (rx_sync != START_BIT) begin
                    active <= 1'b0;
                end
            end else if (bit_idx != STOP_IDX) begin
                shreg <= {rx_sync, shreg[7:1]};
            end else begin
                active <= 1'b0;
            end
        end else if (active) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfm_poll_master.sv
// CFM-side LCB poll initiator: send one command byte, turn the RS485 bus, collect a fixed-length answer.
// Latency: 10*BAUD_DIV TX cycles + TURN_GAP + answer time; result pulse one cycle after the last stop sample.
// Backpressure: none; start is accepted only when idle, answer bytes are never stalled.
//
// Optional feature macro: CFM_CHECKSUM_EN (last answer byte is XOR of the others; adds err_chk).
//
// Ports:
//   clk, rst                 80 MHz system clock, synchronous active-low reset
//   start, cmd               one-cycle poll request and its command byte
//   busy                     poll in progress (accepted start until result pulse)
//   tx, dirTX, dirRX         UART out (idle high), RS485 driver enable, receiver enable (active low)
//   rx                       asynchronous UART in
//   rd_addr, rd_data         answer buffer read port, 1-cycle registered
//   byte_cnt                 answer bytes stored in the current poll
//   done, err_timeout, err_frame, [err_chk]   one-cycle result pulses
module cfm_poll_master
    import cfm_poll_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV,
    parameter int RESP_LEN = DEF_RESP_LEN,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int TURN_GAP = DEF_TURN_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       tx,
    output logic       dirTX,
    output logic       dirRX,
    input  logic       rx,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] byte_cnt,
    output logic       done,
    output logic       err_timeout,
    output logic       err_frame
`ifdef CFM_CHECKSUM_EN
    ,
    output logic       err_chk
`endif
);

    localparam int            BW          = $clog2(BAUD_DIV);
    localparam int            GW          = $clog2(TURN_GAP);
    localparam int            TW          = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUD_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(TURN_GAP - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [3:0]    TX_LAST_BIT = 4'(DATA_BITS + 1);
    localparam logic [5:0]    LAST_BYTE   = 6'(RESP_LEN - 1);
    localparam logic [5:0]    FULL_CNT    = 6'(RESP_LEN);

    state_t        state;
    state_t        state_nxt;
    fin_t          fin_reason;
    fin_t          fin_nxt;

    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    tx_shift;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic          baud_end;

    logic          rx_en;
    logic          start_seen;
    logic          false_start;
    logic          byte_valid;
    logic          frame_err;
    logic [7:0]    byte_data;
    logic          buf_we;

    logic [7:0]    resp_buf [32];

    assign baud_end = (baud_cnt == BAUD_LAST);
    // Kept outside the FSM block so the receiver's start_seen does not loop back through it.
    assign rx_en    = (state == RX_WAIT) || (state == RX_BIT);
    assign buf_we   = rst && (state == RX_BIT) && byte_valid && (byte_cnt != FULL_CNT);

    cfm_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .enable      (rx_en),
        .start_seen  (start_seen),
        .false_start (false_start),
        .byte_valid  (byte_valid),
        .frame_err   (frame_err),
        .byte_data   (byte_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            fin_reason <= FIN_DONE;
        end else begin
            state      <= state_nxt;
            fin_reason <= fin_nxt;
        end
    end

    // Next state and outputs; outputs decode registered state only, so none depends on start or rx.
    always_comb begin
        state_nxt   = state;
        fin_nxt     = fin_reason;
        busy        = 1'b0;
        dirTX       = 1'b0;
        tx          = 1'b1;
        done        = 1'b0;
        err_timeout = 1'b0;
        err_frame   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = TX_BIT;
                end
            end
            TX_BIT: begin
                busy  = 1'b1;
                dirTX = 1'b1;
                tx    = tx_shift[0];
                if (baud_end && (bit_idx == TX_LAST_BIT)) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = RX_WAIT;
                end
            end
            RX_WAIT: begin
                busy = 1'b1;
                // An edge arriving on the last timeout cycle still wins.
                if (start_seen) begin
                    state_nxt = RX_BIT;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = FINISH;
                    fin_nxt   = FIN_TIMEOUT;
                end
            end
            RX_BIT: begin
                busy = 1'b1;
                if (frame_err) begin
                    state_nxt = FINISH;
                    fin_nxt   = FIN_FRAME;
                end else if (byte_valid) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = FINISH;
                        fin_nxt   = FIN_DONE;
                    end else begin
                        state_nxt = RX_WAIT;
                    end
                end else if (false_start) begin
                    state_nxt = RX_WAIT;
                end
            end
            FINISH: begin
                state_nxt   = IDLE;
                done        = (fin_reason == FIN_DONE);
                err_timeout = (fin_reason == FIN_TIMEOUT);
                err_frame   = (fin_reason == FIN_FRAME);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        dirRX = dirTX;
    end

    // TX shifter, turnaround gap, timeout counter and byte counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_shift <= '1;
            gap_cnt  <= '0;
            to_cnt   <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift <= {STOP_BIT, cmd, START_BIT};
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        byte_cnt <= '0;
                    end
                end
                TX_BIT: begin
                    gap_cnt <= '0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                        tx_shift <= {1'b1, tx_shift[9:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    to_cnt  <= '0;
                end
                RX_WAIT: begin
                    if (!start_seen) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RX_BIT: begin
                    // Counter is held here, so a false start resumes the same wait budget.
                    if (byte_valid && (byte_cnt != FULL_CNT)) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        to_cnt   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Answer buffer survives reset; read returns pre-write data on an address collision.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            resp_buf[byte_cnt[4:0]] <= byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= resp_buf[rd_addr];
        end
    end

`ifdef CFM_CHECKSUM_EN
    logic [7:0] chk_acc;
    logic       chk_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_acc <= '0;
            chk_bad <= 1'b0;
        end else if ((state == IDLE) && start) begin
            chk_acc <= '0;
            chk_bad <= 1'b0;
        end else if (buf_we) begin
            if (byte_cnt == LAST_BYTE) begin
                chk_bad <= (byte_data != chk_acc);
            end else begin
                chk_acc <= chk_acc ^ byte_data;
            end
        end
    end

    assign err_chk = done && chk_bad;
`endif

endmodule

// File: tb/tb_cfm_poll_master.sv
// Directed bench for cfm_poll_master: reset, command waveform, full answer, timeout, framing, abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_cfm_poll_master;

    localparam int BAUD = 16;
    localparam int RLEN = 32;
    localparam int TOUT = 4096;
    localparam int TGAP = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cmd;
    logic       busy;
    logic       tx;
    logic       dirTX;
    logic       dirRX;
    logic       rx;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] byte_cnt;
    logic       done;
    logic       err_timeout;
    logic       err_frame;
`ifdef CFM_CHECKSUM_EN
    logic       err_chk;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, written only by the monitor process
    int   cyc = 0;
    int   n_done = 0;
    int   n_to = 0;
    int   n_fr = 0;
    int   to_cyc = 0;
    int   n_txlow = 0;
    int   n_dir = 0;
    logic busy_at_pulse = 1'b1;

    always #5 clk = ~clk;

    cfm_poll_master #(
        .BAUD_DIV (BAUD),
        .RESP_LEN (RLEN),
        .TIMEOUT  (TOUT),
        .TURN_GAP (TGAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmd         (cmd),
        .busy        (busy),
        .tx          (tx),
        .dirTX       (dirTX),
        .dirRX       (dirRX),
        .rx          (rx),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .byte_cnt    (byte_cnt),
        .done        (done),
        .err_timeout (err_timeout),
        .err_frame   (err_frame)
`ifdef CFM_CHECKSUM_EN
        ,
        .err_chk     (err_chk)
`endif
    );

    always @(posedge clk) begin
        #1;
        cyc++;
        if (done) n_done++;
        if (err_timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (err_frame) n_fr++;
        if (done || err_timeout || err_frame) busy_at_pulse = busy;
        if (!tx) n_txlow++;
        if (dirTX) n_dir++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_poll(input logic [7:0] c, output int acc_cyc);
        @(negedge clk);
        cmd     = c;
        start   = 1'b1;
        acc_cyc = cyc + 1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic read_buf(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a_cyc;
        int         bad;
        int         dir_hi;
        int         dir_ne;
        int         snap0;
        int         snap1;
        int         snap2;
        logic       txs [200];
        logic [9:0] tx_seq_exp;
        logic [7:0] d;

        rst = 1'b0; start = 1'b0; cmd = 8'h00; rx = 1'b1; rd_addr = 5'd0;

        // 1. Reset
        repeat (3) @(negedge clk);
        check_eq("rst_rd_data", rd_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_dirtx", dirTX, 1'b0);
        check_eq("rst_dirrx", dirRX, 1'b0);
        check_eq("rst_byte_cnt", byte_cnt, 6'd0);
        check_eq("rst_pulses", {done, err_timeout, err_frame}, 3'b000);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || dirTX !== 1'b0 || dirRX !== 1'b0 || busy !== 1'b0 || byte_cnt !== 6'd0) bad++;
        end
        check_eq("idle_stable", bad, 0);
        check_eq("idle_pulses", n_done + n_to + n_fr, 0);

        // 2. Command waveform: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 (first bit in bit 0)
        tx_seq_exp = 10'b11_0100_1010;
        start_poll(8'hA5, a_cyc);
        check_eq("tx_busy", busy, 1'b1);
        dir_hi = 0;
        dir_ne = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) @(negedge clk);
            txs[i] = tx;
            if (dirTX) dir_hi++;
            if (dirRX !== dirTX) dir_ne++;
        end
        for (int k = 0; k < 10; k++) check_eq($sformatf("tx_bit%0d", k), txs[16 * k + 8], tx_seq_exp[k]);
        bad = 0;
        for (int i = 0; i < 160; i++) if (txs[i] !== tx_seq_exp[i / 16]) bad++;
        for (int i = 160; i < 200; i++) if (txs[i] !== 1'b1) bad++;
        check_eq("tx_spacing", bad, 0);
        check_eq("dirtx_len", dir_hi, 160);
        check_eq("dirrx_eq_dirtx", dir_ne, 0);

        // 3. Full answer 0x00..0x1F
        snap0 = n_done;
        for (int b = 0; b < RLEN; b++) send_byte(8'(b), 1'b1);
        for (int i = 0; i < 300 && n_done == snap0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq("full_done_cnt", n_done - snap0, 1);
        check_eq("full_busy_at_done", busy_at_pulse, 1'b0);
        check_eq("full_byte_cnt", byte_cnt, 6'd32);
        check_eq("full_busy_after", busy, 1'b0);
        read_buf(5'd5, d);
        check_eq("full_rd5", d, 8'h05);
        read_buf(5'd31, d);
        check_eq("full_rd31", d, 8'h1F);

        // 4. Silent LCB: timeout = 160 TX + 32 gap + 4096 wait cycles after accept
        snap0 = n_to;
        snap1 = n_done;
        start_poll(8'h3C, a_cyc);
        for (int i = 0; i < 5000 && n_to == snap0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("to_cnt", n_to - snap0, 1);
        check_eq("to_latency", to_cyc - a_cyc, 4288);
        check_eq("to_busy_at_pulse", busy_at_pulse, 1'b0);
        check_eq("to_busy", busy, 1'b0);
        check_eq("to_byte_cnt", byte_cnt, 6'd0);
        check_eq("to_no_done", n_done - snap1, 0);

        // 5. Framing error on third byte
        snap0 = n_fr;
        start_poll(8'h5A, a_cyc);
        repeat (200) @(negedge clk);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        send_byte(8'hEE, 1'b0);
        for (int i = 0; i < 100 && n_fr == snap0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("fr_cnt", n_fr - snap0, 1);
        check_eq("fr_byte_cnt", byte_cnt, 6'd2);
        check_eq("fr_busy", busy, 1'b0);
        read_buf(5'd0, d);
        check_eq("fr_rd0", d, 8'h77);
        read_buf(5'd1, d);
        check_eq("fr_rd1", d, 8'h88);
        read_buf(5'd2, d);
        check_eq("fr_rd2_kept", d, 8'h02);

        // 6. Start while busy, reset mid-frame, then a clean poll
        start_poll(8'h11, a_cyc);
        repeat (200) @(negedge clk);
        snap0 = n_txlow;
        snap1 = n_dir;
        cmd   = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("busy_start_no_tx", n_txlow - snap0, 0);
        check_eq("busy_start_no_dir", n_dir - snap1, 0);
        check_eq("busy_start_busy", busy, 1'b1);
        for (int b = 0; b < 9; b++) send_byte(8'(b), 1'b1);
        check_eq("abort_pre_cnt", byte_cnt, 6'd9);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        snap0 = n_done + n_to + n_fr;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_tx", tx, 1'b1);
        check_eq("abort_byte_cnt", byte_cnt, 6'd0);
        repeat (50) @(negedge clk);
        check_eq("abort_no_pulse", n_done + n_to + n_fr - snap0, 0);

        snap2 = n_done;
        start_poll(8'h42, a_cyc);
        repeat (200) @(negedge clk);
        for (int b = 0; b < RLEN; b++) send_byte(8'(8'h80 + b), 1'b1);
        for (int i = 0; i < 300 && n_done == snap2; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_eq("repoll_done_cnt", n_done - snap2, 1);
        check_eq("repoll_byte_cnt", byte_cnt, 6'd32);
        read_buf(5'd10, d);
        check_eq("repoll_rd10", d, 8'h8A);
        read_buf(5'd31, d);
        check_eq("repoll_rd31", d, 8'h9F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
